// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding and parameter defaults.
// The optional stall counter is enabled with the FETCH_STALL_COUNT_EN macro.
package fetch_unit_pkg;

    localparam int PC_W_DEF     = 7;
    localparam int INSTR_W_DEF  = 32;
    localparam int RESET_PC_DEF = 0;
    localparam int STALL_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched word (and its next_pc) while the IF/ID latch is stalled.
// Clear wins over load so a redirect always drops the parked word.
module fetch_hold_buf
    import fetch_unit_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] data_o,
    output logic [PC_W-1:0]    pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic [PC_W-1:0]    pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
            pc_d    = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            pc_d    = pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one-outstanding req/ack fetches and feeds the IF/ID latch.
// Define FETCH_STALL_COUNT_EN to add the saturating stall_cycles counter output.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stop,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    next_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               ena
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [STALL_W-1:0] stall_cycles
`endif
);

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
    logic [PC_W-1:0]    next_pc_q, next_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               ena_q, ena_d;
    logic [PC_W-1:0]    pc_plus1;

    logic               hold_load, hold_clear, hold_valid;
    logic [INSTR_W-1:0] hold_data;
    logic [PC_W-1:0]    hold_pc;

    assign pc_plus1 = pc_q + PC_ONE;

    fetch_hold_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .data_i  (imem_rdata),
        .pc_i    (pc_plus1),
        .valid_o (hold_valid),
        .data_o  (hold_data),
        .pc_o    (hold_pc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        next_pc_d    = next_pc_q;
        instr_d      = instr_q;
        ena_d        = ena_q;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;

        if (branch_taken) begin
            // Redirect overrides stop: presented and parked words both die here.
            pc_d       = branch_target;
            ena_d      = 1'b0;
            hold_clear = 1'b1;
            unique case (state_q)
                REQ: begin
                    if (imem_ack) begin
                        state_d = REQ;
                    end else begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                DRAIN:   state_d = imem_ack ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                IDLE: state_d = REQ;
                DRAIN: begin
                    if (imem_ack) state_d = REQ;
                    if (!stop) ena_d = 1'b0;
                end
                HOLD: begin
                    if (!stop) begin
                        instr_d    = hold_data;
                        next_pc_d  = hold_pc;
                        ena_d      = hold_valid;
                        hold_clear = 1'b1;
                        state_d    = REQ;
                    end
                end
                REQ: begin
                    if (stop) begin
                        if (imem_ack) begin
                            hold_load = 1'b1;
                            pc_d      = pc_plus1;
                            state_d   = HOLD;
                        end
                    end else if (imem_ack) begin
                        instr_d   = imem_rdata;
                        next_pc_d = pc_plus1;
                        ena_d     = 1'b1;
                        pc_d      = pc_plus1;
                    end else begin
                        ena_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= PC_RST;
            drain_addr_q <= PC_RST;
            next_pc_q    <= '0;
            instr_q      <= '0;
            ena_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            next_pc_q    <= next_pc_d;
            instr_q      <= instr_d;
            ena_q        <= ena_d;
        end
    end

    // A draining request keeps its original address so the handshake stays stable.
    assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign next_pc     = next_pc_q;
    assign instruction = instr_q;
    assign ena         = ena_q;

`ifdef FETCH_STALL_COUNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (stop && (stall_q != {STALL_W{1'b1}})) stall_d = stall_q + STALL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/branch/ack/reset traffic,
// with the consumed instruction stream checked against a sequential-PC reference queue.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stop = 1'b0;
    logic        branch_taken = 1'b0;
    logic [6:0]  branch_target = '0;
    logic        imem_req;
    logic [6:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [6:0]  next_pc;
    logic [31:0] instruction;
    logic        ena;

    logic        rst_w = 1'b1;
    logic        stop_w = 1'b0;
    logic        br_w = 1'b0;
    logic [6:0]  tgt_w = '0;
    logic        ack_w = 1'b1;
    logic        req_w;
    logic [6:0]  addr_w;
    logic [31:0] rdata_w;
    logic [6:0]  next_pc_w;
    logic [31:0] instr_w;
    logic        ena_w;

`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_cycles, stall_cycles_w;
    logic [15:0] stall_exp;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic        ack_any = 1'b0;

    logic [38:0] exp_q[$];
    logic [6:0]  fill_pc;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(7), .INSTR_W(32), .RESET_PC(0)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stop          (stop),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .next_pc       (next_pc),
        .instruction   (instruction),
        .ena           (ena)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    assign rdata_w = {23'd0, addr_w, 2'b00};

    fetch_unit #(.PC_W(7), .INSTR_W(32), .RESET_PC(126)) u_wrap (
        .clk           (clk),
        .rst           (rst_w),
        .stop          (stop_w),
        .branch_taken  (br_w),
        .branch_target (tgt_w),
        .imem_req      (req_w),
        .imem_addr     (addr_w),
        .imem_ack      (ack_w),
        .imem_rdata    (rdata_w),
        .next_pc       (next_pc_w),
        .instruction   (instr_w),
        .ena           (ena_w)
`ifdef FETCH_STALL_COUNT_EN
        ,
        .stall_cycles  (stall_cycles_w)
`endif
    );

    function automatic logic [31:0] mem(input logic [6:0] a);
        return {23'd0, a, 2'b00};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 64) begin
            exp_q.push_back({fill_pc + 7'd1, mem(fill_pc)});
            fill_pc = fill_pc + 7'd1;
        end
    endtask

    task automatic refill(input logic [6:0] start);
        exp_q.delete();
        fill_pc = start;
        topup();
    endtask

    // Memory responder: acks only live requests unless ack_any forces a stray ack.
    task automatic drive(input logic r, input logic s, input logic b,
                         input logic [6:0] t, input int ack_pct);
        @(negedge clk);
        rst           = r;
        stop          = s;
        branch_taken  = b;
        branch_target = t;
        imem_ack      = (imem_req || ack_any) && ($urandom_range(99) < ack_pct);
        imem_rdata    = (imem_ack && imem_req) ? mem(imem_addr) : $urandom;
    endtask

    // Monitor / scoreboard: samples 1 time unit before each rising edge.
    logic        after_rst = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_pending, prev_stop, prev_br;
    logic [6:0]  prev_addr, prev_npc;
    logic [31:0] prev_instr;
    logic        prev_ena;
    int          idle_cnt = 0;
    logic [38:0] item;

    always @(negedge clk) begin
        #4;
        if (after_rst) begin
            chk("rst_ena", ena, 1'b0);
            chk("rst_instr", instruction, 32'd0);
            chk("rst_next_pc", next_pc, 7'd0);
            chk("rst_req", imem_req, 1'b0);
            after_rst = 1'b0;
        end
        if (prev_valid) begin
            if (prev_pending) begin
                chk("req_stable", imem_req, 1'b1);
                chk("addr_stable", imem_addr, prev_addr);
            end
            if (prev_stop && !prev_br) begin
                chk("frozen_ena", ena, prev_ena);
                chk("frozen_instr", instruction, prev_instr);
                chk("frozen_next_pc", next_pc, prev_npc);
            end
            if (prev_br) chk("branch_bubble", ena, 1'b0);
        end
`ifdef FETCH_STALL_COUNT_EN
        if (!$isunknown(stall_exp)) chk("stall_cycles", stall_cycles, stall_exp);
`endif
        if (!rst && !stop && ena === 1'b1) begin
            idle_cnt = 0;
            if (exp_q.size() == 0) begin
                chk("queue_underrun", 1'b1, 1'b0);
            end else begin
                item = exp_q.pop_front();
                chk("stream_instr", instruction, item[31:0]);
                chk("stream_next_pc", next_pc, item[38:32]);
            end
        end else if (!rst && !stop) begin
            idle_cnt++;
            if (idle_cnt > 400) begin
                chk("progress_timeout", 1'b0, 1'b1);
                idle_cnt = 0;
            end
        end
        if (rst) begin
            after_rst  = 1'b1;
            prev_valid = 1'b0;
            idle_cnt   = 0;
            refill(7'd0);
`ifdef FETCH_STALL_COUNT_EN
            stall_exp = 16'd0;
`endif
        end else begin
            prev_valid   = 1'b1;
            prev_pending = imem_req && !imem_ack;
            prev_stop    = stop;
            prev_br      = branch_taken;
            prev_addr    = imem_addr;
            prev_npc     = next_pc;
            prev_instr   = instruction;
            prev_ena     = ena;
            if (branch_taken) refill(branch_target);
`ifdef FETCH_STALL_COUNT_EN
            if (stop && stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
`endif
            topup();
        end
    end

    logic [6:0] old_addr;
    logic [6:0] w_addrs[$];
    logic [6:0] w_npcs[$];
    logic [31:0] w_instrs[$];

    initial begin
`ifdef FETCH_STALL_COUNT_EN
        stall_exp = 'x;
`endif
        // Wrap instance: addresses 126,127,0,1 with main DUT held in reset.
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rst_w = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 0);
            #4;
            if (req_w) w_addrs.push_back(addr_w);
            if (ena_w) begin
                w_npcs.push_back(next_pc_w);
                w_instrs.push_back(instr_w);
            end
        end
        chk("wrap_addr_count", (w_addrs.size() >= 4), 1'b1);
        chk("wrap_npc_count", (w_npcs.size() >= 3), 1'b1);
        if (w_addrs.size() >= 4) begin
            chk("wrap_addr0", w_addrs[0], 7'd126);
            chk("wrap_addr1", w_addrs[1], 7'd127);
            chk("wrap_addr2", w_addrs[2], 7'd0);
            chk("wrap_addr3", w_addrs[3], 7'd1);
        end
        if (w_npcs.size() >= 3) begin
            chk("wrap_npc0", w_npcs[0], 7'd127);
            chk("wrap_npc1", w_npcs[1], 7'd0);
            chk("wrap_npc2", w_npcs[2], 7'd1);
            chk("wrap_instr0", w_instrs[0], 32'd504);
            chk("wrap_instr2", w_instrs[2], 32'd0);
        end

        // Free run with continuous ack; stray ack right after reset must be ignored.
        ack_any = 1'b1;
        drive(1, 0, 0, 0, 100);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 0, 0, 100);
            #4;
            if (i <= 2) chk("fr_ena_low", ena, 1'b0);
            if (i >= 2) chk("fr_addr", imem_addr, 7'(i - 2));
            if (i >= 3) begin
                chk("fr_ena", ena, 1'b1);
                chk("fr_instr", instruction, 32'((i - 3) * 4));
                chk("fr_next_pc", next_pc, 7'(i - 2));
            end
        end
        ack_any = 1'b0;

        // Stop for three cycles with ack held high.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0, 100);
            #4;
            if (k > 0) chk("hold_req_low", imem_req, 1'b0);
        end
        drive(0, 0, 0, 0, 100);
        #4;
        chk("hold_req_low_release", imem_req, 1'b0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 100);

        // Branch while a slow request is pending.
        drive(0, 0, 0, 0, 0);
        #4;
        old_addr = imem_addr;
        chk("pre_branch_req", imem_req, 1'b1);
        drive(0, 0, 1, 7'd40, 0);
        drive(0, 0, 0, 0, 0);
        #4;
        chk("drain_req", imem_req, 1'b1);
        chk("drain_addr", imem_addr, old_addr);
        chk("drain_ena", ena, 1'b0);
        drive(0, 0, 0, 0, 100);
        #4;
        chk("drain_addr_ack", imem_addr, old_addr);
        drive(0, 0, 0, 0, 100);
        #4;
        chk("target_req", imem_req, 1'b1);
        chk("target_addr", imem_addr, 7'd40);
        drive(0, 0, 0, 0, 100);
        #4;
        chk("target_ena", ena, 1'b1);
        chk("target_next_pc", next_pc, 7'd41);
        chk("target_instr", instruction, 32'd160);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 100);

        // Branch and stop in the same cycle.
        drive(0, 1, 1, 7'd90, 100);
        drive(0, 1, 0, 0, 100);
        #4;
        chk("bs_ena", ena, 1'b0);
        chk("bs_addr", imem_addr, 7'd90);
        drive(0, 0, 0, 0, 100);
        #4;
        chk("bs_hold_req", imem_req, 1'b0);
        drive(0, 0, 0, 0, 100);
        #4;
        chk("bs_ena_after", ena, 1'b1);
        chk("bs_instr", instruction, 32'd360);
        chk("bs_next_pc", next_pc, 7'd91);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 100);

        // Reset with a request outstanding and a stray ack just after.
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        ack_any = 1'b1;
        drive(0, 0, 0, 0, 100);
        #4;
        chk("mid_rst_req", imem_req, 1'b0);
        chk("mid_rst_ena", ena, 1'b0);
        drive(0, 0, 0, 0, 100);
        #4;
        chk("mid_rst_addr", imem_addr, 7'd0);
        chk("mid_rst_ena_ignored", ena, 1'b0);
        drive(0, 0, 0, 0, 100);
        #4;
        chk("mid_rst_first_npc", next_pc, 7'd1);
        ack_any = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(149) == 0),
                  ($urandom_range(99) < 30),
                  ($urandom_range(99) < 4),
                  7'($urandom_range(127)),
                  60);
        end

`ifdef FETCH_STALL_COUNT_EN
        drive(1, 0, 0, 0, 100);
        for (int i = 0; i < 65540; i++) drive(0, 1, 0, 0, 100);
        #4;
        chk("stall_saturate", stall_cycles, 16'hFFFF);
        drive(1, 0, 0, 0, 100);
        drive(0, 0, 0, 0, 100);
        #4;
        chk("stall_reset", stall_cycles, 16'd0);
`endif

        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 100);
        @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the PC, requests words from instruction memory over a req/ack handshake, and presents next_pc, instruction and ena to the IF/ID pipeline latch.
- Honours the hazard-unit stop signal and branch redirects (flush).
- Producer end of the IF/ID interface; one request outstanding at a time.

Parameters:
- PC_W, 7, PC/address width (word-indexed).
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- stop  input  1  downstream stall; when 1, the IF/ID latch does not sample at this edge
- branch_taken  input  1  redirect/flush request
- branch_target  input  PC_W  redirect PC
- imem_req  output  1  memory request
- imem_addr  output  PC_W  request address (= pc)
- imem_ack  input  1  data valid this cycle
- imem_rdata  input  INSTR_W  fetched word
- next_pc  output  PC_W  PC+1 of the presented instruction
- instruction  output  INSTR_W  presented instruction
- ena  output  1  presented instruction is valid (0 = bubble)

Behaviour:
- Reset (sync, rst=1 at edge):
  - pc=RESET_PC, state=IDLE, next_pc=0, instruction=0, ena=0, hold buffer=0, imem_req=0.
  - An imem_ack in the cycle after reset is ignored.
- States:
  - IDLE: req=0; next edge goes to REQ.
  - REQ: req=1, imem_addr=pc.
  - HOLD: req=0; a fetched word is buffered.
  - DRAIN: req=1 at the old address; the response will be discarded.
- Handshake: imem_req and imem_addr stay stable until an edge where imem_ack=1. No new request is issued in the ack cycle's own edge decision except as listed below.
- Priority at each edge: rst > branch_taken > stop > normal.
- branch_taken=1:
  - pc<=branch_target, ena<=0, hold buffer invalidated. This applies regardless of stop.
  - If REQ and imem_ack=1: data discarded, state REQ (next request at target).
  - If REQ and imem_ack=0: state DRAIN.
  - HOLD/IDLE: go to REQ.
  - DRAIN: stay DRAIN (pc retargeted).
- DRAIN:
  - On ack: discard data, state REQ.
  - Outputs keep ena=0 until a post-branch word arrives.
- stop=1, no branch:
  - Outputs frozen (next_pc, instruction, ena unchanged).
  - REQ with ack: hold<=rdata, hold_pc<=pc+1, pc<=pc+1, state HOLD.
  - REQ without ack: stay REQ.
- stop=0, no branch:
  - HOLD: outputs<=hold buffer, ena<=1, state REQ.
  - REQ with ack: instruction<=imem_rdata, next_pc<=pc+1, ena<=1, pc<=pc+1, stay REQ. Back-to-back gives 1 instruction/cycle when memory acks combinationally.
  - REQ without ack: ena<=0 (bubble), other outputs unchanged.
- Latency: ack at edge N gives valid outputs after edge N (ena=1 in cycle N+1).
- Arithmetic: pc+1 is modulo 2^PC_W; 127 wraps to 0 with no flag.
- Reset mid-request: request is abandoned, any pending data is lost, and fetch restarts at RESET_PC.

Optional Feature:
- Macro FETCH_STALL_COUNT_EN.
- Defined: adds output stall_cycles (16 bits). It increments on every edge with stop=1 and rst=0, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared pipeline package: state encoding (IDLE, REQ, HOLD, DRAIN as 2-bit constants), PC_W/INSTR_W defaults, RESET_PC.
- One natural sub-module: fetch_hold_buf, a one-entry buffer (load, clear, valid, data, pc) used for HOLD.
- The FSM and PC stay in fetch_unit.

Test Plan:
- Reset then free run, imem_ack tied 1, rdata=addr*4: ena=1 from 3rd cycle; outputs in order (0,next_pc=1), (4,2), (8,3) …; imem_addr increments by 1 per cycle.
- stop=1 for 3 cycles while ack=1:
  - Outputs frozen.
  - Exactly one word captured in HOLD; req=0 during HOLD.
  - After stop falls, held word appears, then fetch resumes with no skipped or duplicate PC.
- Memory with 2-cycle ack latency, branch_taken at target 40 mid-wait:
  - imem_addr holds old value until ack (DRAIN).
  - Old data never appears with ena=1.
  - Next request has addr=40; first valid output has next_pc=41.
- Branch and stop in the same cycle: ena->0, pc->target, hold cleared; after stop falls, first valid instruction is from the target.
- PC wrap: RESET_PC=126, continuous ack: addresses 126, 127, 0, 1; next_pc outputs 127, 0, 1.
- rst asserted with request outstanding and ack arriving next cycle: all outputs 0, ack ignored, first new request addr=RESET_PC. With FETCH_STALL_COUNT_EN, stall_cycles returns to 0 and saturates at 65535 under a sustained stop.
